// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcode/func constants, state and encoding types for multicycle_control
package control_pkg;

    localparam logic [5:0] OP_ARITH = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_NOR = 6'b100111;
    localparam logic [5:0] FUNC_XOR = 6'b100110;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_t;

    function automatic instr_class_t classify(input logic [5:0] op);
        case (op)
            OP_ARITH:            return CLS_RTYPE;
            OP_ADDI:             return CLS_ADDI;
            OP_LB, OP_LH, OP_LW: return CLS_LOAD;
            OP_SB, OP_SH, OP_SW: return CLS_STORE;
            OP_BEQ, OP_BNE:      return CLS_BRANCH;
            OP_J:                return CLS_JUMP;
            default:             return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [1:0] access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_SB: return SIZE_BYTE;
            OP_LH, OP_SH: return SIZE_HALF;
            default:      return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - bounds the cycles spent waiting on data memory
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // ready in the final cycle wins over expiry
    assign expired = enable && !ready && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !ready && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM; CONTROL_BRANCH_EN adds beq/bne/j
module multicycle_control
    import control_pkg::*;
#(
    parameter int FUNC_W         = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [5:0]        opcode_in,
    input  logic [FUNC_W-1:0] func_in,
    input  logic              instr_valid_in,
    input  logic              mem_ready_in,
    input  logic              zero_in,
    output logic              pc_enable_out,
    output logic [1:0]        pc_src_out,
    output logic              instr_mem_re_out,
    output logic              instr_mux_select_out,
    output logic              regfile_we_out,
    output logic              alu_mux_select_out,
    output logic [FUNC_W-1:0] alu_func_out,
    output logic              data_mem_re_out,
    output logic              data_mem_we_out,
    output logic              data_mem_mux_select_out,
    output logic [1:0]        data_mem_size_out,
    output logic [2:0]        state_out,
    output logic              illegal_out,
    output logic              timeout_out
);
    state_t            state, state_n;
    logic [5:0]        op_q;
    logic [FUNC_W-1:0] func_q;
    instr_class_t      cls_q, cls_d;
    logic              expired;

`ifndef CONTROL_BRANCH_EN
    logic unused_zero;
    assign unused_zero = zero_in;
`endif

    always_comb begin
        cls_d = classify(opcode_in);
`ifndef CONTROL_BRANCH_EN
        if (cls_d == CLS_BRANCH || cls_d == CLS_JUMP) cls_d = CLS_ILLEGAL;
`endif
    end

    // Instruction fields are captured as the fetch completes so every later
    // output, including the DECODE illegal pulse, comes from registered state.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state  <= S_FETCH;
            op_q   <= '0;
            func_q <= '0;
            cls_q  <= CLS_RTYPE;
        end else begin
            state <= state_n;
            if (state == S_FETCH && instr_valid_in) begin
                op_q   <= opcode_in;
                func_q <= func_in;
                cls_q  <= cls_d;
            end
        end
    end

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk_in),
        .reset   (reset_in),
        .clear   (state != S_MEM),
        .enable  (state == S_MEM && !reset_in),
        .ready   (mem_ready_in),
        .expired (expired)
    );

    always_comb begin
        state_n                 = state;
        pc_enable_out           = 1'b0;
        pc_src_out              = PC_SRC_SEQ;
        instr_mem_re_out        = 1'b0;
        instr_mux_select_out    = 1'b0;
        regfile_we_out          = 1'b0;
        alu_mux_select_out      = 1'b0;
        alu_func_out            = FUNC_W'(FUNC_ADD);
        data_mem_re_out         = 1'b0;
        data_mem_we_out         = 1'b0;
        data_mem_mux_select_out = 1'b0;
        data_mem_size_out       = SIZE_WORD;
        state_out               = 3'd0;
        illegal_out             = 1'b0;
        timeout_out             = 1'b0;
        if (!reset_in) begin
            state_out = state;
            case (state)
                S_FETCH: begin
                    instr_mem_re_out = 1'b1;
                    if (instr_valid_in) state_n = S_DECODE;
                end
                S_DECODE: begin
                    illegal_out = (cls_q == CLS_ILLEGAL);
                    state_n     = S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        CLS_RTYPE: begin
                            alu_func_out = func_q;
                            state_n      = S_WB;
                        end
                        CLS_ADDI: begin
                            alu_mux_select_out = 1'b1;
                            state_n            = S_WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_mux_select_out = 1'b1;
                            state_n            = S_MEM;
                        end
`ifdef CONTROL_BRANCH_EN
                        CLS_BRANCH: begin
                            alu_func_out  = FUNC_W'(FUNC_SUB);
                            pc_enable_out = 1'b1;
                            if ((op_q == OP_BEQ) == zero_in) pc_src_out = PC_SRC_BRANCH;
                            state_n = S_FETCH;
                        end
                        CLS_JUMP: begin
                            pc_enable_out = 1'b1;
                            pc_src_out    = PC_SRC_JUMP;
                            state_n       = S_FETCH;
                        end
`endif
                        default: begin
                            pc_enable_out = 1'b1;
                            state_n       = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    data_mem_size_out = access_size(op_q);
                    data_mem_re_out   = (cls_q == CLS_LOAD) && !expired;
                    data_mem_we_out   = (cls_q == CLS_STORE) && !expired;
                    if (mem_ready_in) begin
                        if (cls_q == CLS_LOAD) begin
                            state_n = S_WB;
                        end else begin
                            pc_enable_out = 1'b1;
                            state_n       = S_FETCH;
                        end
                    end else if (expired) begin
                        timeout_out   = 1'b1;
                        pc_enable_out = 1'b1;
                        state_n       = S_FETCH;
                    end
                end
                S_WB: begin
                    regfile_we_out          = 1'b1;
                    pc_enable_out           = 1'b1;
                    data_mem_mux_select_out = (cls_q == CLS_LOAD);
                    instr_mux_select_out    = (cls_q == CLS_RTYPE);
                    state_n                 = S_FETCH;
                end
                default: state_n = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control
module tb_multicycle_control;
    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [5:0] opcode_in;
    logic [5:0] func_in;
    logic       instr_valid_in, mem_ready_in, zero_in;
    logic       pc_enable_out;
    logic [1:0] pc_src_out;
    logic       instr_mem_re_out, instr_mux_select_out, regfile_we_out, alu_mux_select_out;
    logic [5:0] alu_func_out;
    logic       data_mem_re_out, data_mem_we_out, data_mem_mux_select_out;
    logic [1:0] data_mem_size_out;
    logic [2:0] state_out;
    logic       illegal_out, timeout_out;

    int vectors = 0;
    int miscompares = 0;

    int cyc, mem_cyc, n_re, n_we, n_rfwe, n_ill, n_to, n_pc, ill_state;
    logic [1:0]  ret_src, mem_size;
    logic        ret_dmux, ret_imux, ret_rfwe, ret_to, exec_amux, post_pc;
    logic [5:0]  exec_func;
    logic [2:0]  post_state;
    logic [31:0] seq;

    always #5 clk_in = ~clk_in;

    multicycle_control #(.FUNC_W(6), .TIMEOUT_CYCLES(16)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .opcode_in(opcode_in), .func_in(func_in),
        .instr_valid_in(instr_valid_in), .mem_ready_in(mem_ready_in), .zero_in(zero_in),
        .pc_enable_out(pc_enable_out), .pc_src_out(pc_src_out),
        .instr_mem_re_out(instr_mem_re_out), .instr_mux_select_out(instr_mux_select_out),
        .regfile_we_out(regfile_we_out), .alu_mux_select_out(alu_mux_select_out),
        .alu_func_out(alu_func_out), .data_mem_re_out(data_mem_re_out),
        .data_mem_we_out(data_mem_we_out), .data_mem_mux_select_out(data_mem_mux_select_out),
        .data_mem_size_out(data_mem_size_out), .state_out(state_out),
        .illegal_out(illegal_out), .timeout_out(timeout_out)
    );

    // Runs one instruction from FETCH to its retire pulse, tallying what each cycle showed.
    // ready_after = number of MEM wait cycles before mem_ready_in (-1: never).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int ready_after, input logic z);
        logic retired;
        opcode_in = op; func_in = fn; zero_in = z; instr_valid_in = 1'b1; mem_ready_in = 1'b0;
        cyc = 0; mem_cyc = 0; n_re = 0; n_we = 0; n_rfwe = 0; n_ill = 0; n_to = 0; n_pc = 0;
        ill_state = -1; seq = 0; retired = 1'b0; mem_size = 2'bxx;
        ret_src = 2'bxx; ret_dmux = 1'bx; ret_imux = 1'bx; ret_rfwe = 1'bx; ret_to = 1'bx;
        exec_func = 6'bx; exec_amux = 1'bx;
        while (!retired && cyc < 100) begin
            mem_ready_in = (state_out == 3'd3) && (mem_cyc == ready_after);
            #1;
            cyc++;
            seq = {seq[28:0], state_out};
            if (data_mem_re_out) n_re++;
            if (data_mem_we_out) n_we++;
            if (regfile_we_out) n_rfwe++;
            if (timeout_out) n_to++;
            if (illegal_out) begin n_ill++; ill_state = int'(state_out); end
            if (state_out == 3'd2) begin exec_func = alu_func_out; exec_amux = alu_mux_select_out; end
            if (state_out == 3'd3) begin mem_size = data_mem_size_out; mem_cyc++; end
            if (pc_enable_out) begin
                n_pc++; retired = 1'b1;
                ret_src = pc_src_out; ret_dmux = data_mem_mux_select_out;
                ret_imux = instr_mux_select_out; ret_rfwe = regfile_we_out; ret_to = timeout_out;
            end
            @(posedge clk_in); #1;
        end
        mem_ready_in = 1'b0;
        #1;
        post_state = state_out;
        post_pc = pc_enable_out;
    endtask

    task automatic test_reset;
        reset_in = 1'b1; opcode_in = 6'h0; func_in = 6'h0;
        instr_valid_in = 1'b1; mem_ready_in = 1'b1; zero_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        vectors++; if (state_out !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d expected 0", state_out); end
        vectors++; if (instr_mem_re_out !== 1'b0) begin miscompares++; $display("FAIL reset_imem_re got %b expected 0", instr_mem_re_out); end
        vectors++; if ({pc_enable_out, regfile_we_out, data_mem_re_out, data_mem_we_out, illegal_out, timeout_out} !== 6'b0)
            begin miscompares++; $display("FAIL reset_strobes got %b expected 000000",
                {pc_enable_out, regfile_we_out, data_mem_re_out, data_mem_we_out, illegal_out, timeout_out}); end
        vectors++; if (alu_func_out !== 6'b100000 || data_mem_size_out !== 2'b11)
            begin miscompares++; $display("FAIL reset_defaults got func %b size %b expected 100000 11", alu_func_out, data_mem_size_out); end
        mem_ready_in = 1'b0; instr_valid_in = 1'b0;
        reset_in = 1'b0;
        #1;
        vectors++; if (instr_mem_re_out !== 1'b1 || state_out !== 3'd0)
            begin miscompares++; $display("FAIL release_fetch got re %b state %0d expected 1 0", instr_mem_re_out, state_out); end
        @(posedge clk_in); #1;
    endtask

    task automatic test_rtype;
        run_instr(6'b000000, 6'b100000, 0, 1'b0);
        vectors++; if (seq !== 32'o0124) begin miscompares++; $display("FAIL add_state_seq got %o expected 124", seq); end
        vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL add_latency got %0d expected 4", cyc); end
        vectors++; if (n_rfwe !== 1 || ret_rfwe !== 1'b1) begin miscompares++; $display("FAIL add_rfwe got %0d/%b expected 1/1", n_rfwe, ret_rfwe); end
        vectors++; if (ret_imux !== 1'b1 || ret_dmux !== 1'b0 || ret_src !== 2'b00)
            begin miscompares++; $display("FAIL add_wb_selects got imux %b dmux %b src %b expected 1 0 00", ret_imux, ret_dmux, ret_src); end
        vectors++; if (exec_func !== 6'b100000) begin miscompares++; $display("FAIL add_exec_func got %b expected 100000", exec_func); end
        vectors++; if (post_state !== 3'd0 || post_pc !== 1'b0) begin miscompares++; $display("FAIL add_after got state %0d pc %b expected 0 0", post_state, post_pc); end
        run_instr(6'b000000, 6'b100010, 0, 1'b0);
        vectors++; if (exec_func !== 6'b100010 || exec_amux !== 1'b0)
            begin miscompares++; $display("FAIL sub_exec got func %b amux %b expected 100010 0", exec_func, exec_amux); end
    endtask

    task automatic test_addi;
        run_instr(6'b001000, 6'b000111, 0, 1'b0);
        vectors++; if (cyc !== 4 || exec_amux !== 1'b1 || exec_func !== 6'b100000)
            begin miscompares++; $display("FAIL addi got cyc %0d amux %b func %b expected 4 1 100000", cyc, exec_amux, exec_func); end
        vectors++; if (ret_imux !== 1'b0 || ret_rfwe !== 1'b1) begin miscompares++; $display("FAIL addi_wb got imux %b we %b expected 0 1", ret_imux, ret_rfwe); end
    endtask

    task automatic test_loads;
        run_instr(6'b100001, 6'b0, 3, 1'b0);
        vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL lh_latency got %0d expected 8", cyc); end
        vectors++; if (n_re !== 4 || n_we !== 0) begin miscompares++; $display("FAIL lh_re_cycles got re %0d we %0d expected 4 0", n_re, n_we); end
        vectors++; if (mem_size !== 2'b01) begin miscompares++; $display("FAIL lh_size got %b expected 01", mem_size); end
        vectors++; if (ret_dmux !== 1'b1 || ret_rfwe !== 1'b1) begin miscompares++; $display("FAIL lh_wb got dmux %b we %b expected 1 1", ret_dmux, ret_rfwe); end
        run_instr(6'b100011, 6'b0, 0, 1'b0);
        vectors++; if (cyc !== 5 || mem_size !== 2'b11 || seq !== 32'o01234)
            begin miscompares++; $display("FAIL lw got cyc %0d size %b seq %o expected 5 11 1234", cyc, mem_size, seq); end
        run_instr(6'b100000, 6'b0, 0, 1'b0);
        vectors++; if (mem_size !== 2'b00 || n_re !== 1) begin miscompares++; $display("FAIL lb got size %b re %0d expected 00 1", mem_size, n_re); end
        // ready arrives on the very cycle the timeout would fire
        run_instr(6'b100011, 6'b0, 15, 1'b0);
        vectors++; if (n_to !== 0 || cyc !== 20 || n_re !== 16 || ret_rfwe !== 1'b1)
            begin miscompares++; $display("FAIL lw_ready_at_limit got to %0d cyc %0d re %0d we %b expected 0 20 16 1", n_to, cyc, n_re, ret_rfwe); end
    endtask

    task automatic test_stores;
        run_instr(6'b101000, 6'b0, 0, 1'b0);
        vectors++; if (cyc !== 4 || n_we !== 1 || mem_size !== 2'b00 || n_rfwe !== 0)
            begin miscompares++; $display("FAIL sb got cyc %0d we %0d size %b rfwe %0d expected 4 1 00 0", cyc, n_we, mem_size, n_rfwe); end
        run_instr(6'b101001, 6'b0, 1, 1'b0);
        vectors++; if (cyc !== 5 || n_we !== 2 || mem_size !== 2'b01)
            begin miscompares++; $display("FAIL sh got cyc %0d we %0d size %b expected 5 2 01", cyc, n_we, mem_size); end
    endtask

    task automatic test_timeout;
        run_instr(6'b101011, 6'b0, -1, 1'b0);
        vectors++; if (cyc !== 19 || mem_cyc !== 16) begin miscompares++; $display("FAIL sw_timeout_len got cyc %0d mem %0d expected 19 16", cyc, mem_cyc); end
        vectors++; if (n_to !== 1 || ret_to !== 1'b1) begin miscompares++; $display("FAIL sw_timeout_pulse got %0d/%b expected 1/1", n_to, ret_to); end
        vectors++; if (n_we !== 15 || n_rfwe !== 0 || n_pc !== 1)
            begin miscompares++; $display("FAIL sw_timeout_strobes got we %0d rfwe %0d pc %0d expected 15 0 1", n_we, n_rfwe, n_pc); end
        vectors++; if (post_state !== 3'd0 || post_pc !== 1'b0) begin miscompares++; $display("FAIL sw_timeout_after got state %0d pc %b expected 0 0", post_state, post_pc); end
    endtask

    task automatic test_illegal;
        run_instr(6'b111111, 6'b0, 0, 1'b0);
        vectors++; if (n_ill !== 1 || ill_state !== 1) begin miscompares++; $display("FAIL illegal_pulse got %0d in state %0d expected 1 in 1", n_ill, ill_state); end
        vectors++; if (cyc !== 3 || seq !== 32'o012 || ret_src !== 2'b00)
            begin miscompares++; $display("FAIL illegal_nop got cyc %0d seq %o src %b expected 3 12 00", cyc, seq, ret_src); end
        vectors++; if (n_re !== 0 || n_we !== 0 || n_rfwe !== 0)
            begin miscompares++; $display("FAIL illegal_strobes got re %0d we %0d rfwe %0d expected 0 0 0", n_re, n_we, n_rfwe); end
    endtask

    task automatic test_branch;
`ifdef CONTROL_BRANCH_EN
        run_instr(6'b000100, 6'b0, 0, 1'b1);
        vectors++; if (cyc !== 3 || ret_src !== 2'b01 || exec_func !== 6'b100010 || n_ill !== 0)
            begin miscompares++; $display("FAIL beq_taken got cyc %0d src %b func %b ill %0d expected 3 01 100010 0", cyc, ret_src, exec_func, n_ill); end
        run_instr(6'b000101, 6'b0, 0, 1'b1);
        vectors++; if (cyc !== 3 || ret_src !== 2'b00) begin miscompares++; $display("FAIL bne_not_taken got cyc %0d src %b expected 3 00", cyc, ret_src); end
        run_instr(6'b000101, 6'b0, 0, 1'b0);
        vectors++; if (ret_src !== 2'b01) begin miscompares++; $display("FAIL bne_taken got src %b expected 01", ret_src); end
        run_instr(6'b000010, 6'b0, 0, 1'b0);
        vectors++; if (cyc !== 3 || ret_src !== 2'b10 || n_rfwe !== 0) begin miscompares++; $display("FAIL j got cyc %0d src %b rfwe %0d expected 3 10 0", cyc, ret_src, n_rfwe); end
`else
        run_instr(6'b000100, 6'b0, 0, 1'b1);
        vectors++; if (n_ill !== 1 || ret_src !== 2'b00 || cyc !== 3)
            begin miscompares++; $display("FAIL beq_disabled got ill %0d src %b cyc %0d expected 1 00 3", n_ill, ret_src, cyc); end
        run_instr(6'b000010, 6'b0, 0, 1'b0);
        vectors++; if (n_ill !== 1 || ret_src !== 2'b00) begin miscompares++; $display("FAIL j_disabled got ill %0d src %b expected 1 00", n_ill, ret_src); end
`endif
    endtask

    task automatic test_reset_mid_mem;
        int  guard;
        logic pc_seen;
        opcode_in = 6'b100011; func_in = 6'b0; instr_valid_in = 1'b1; mem_ready_in = 1'b0;
        guard = 0;
        while (state_out !== 3'd3 && guard < 10) begin
            @(posedge clk_in); #1; guard++;
        end
        vectors++; if (state_out !== 3'd3) begin miscompares++; $display("FAIL mid_mem_reach got state %0d expected 3", state_out); end
        @(posedge clk_in); #1;
        reset_in = 1'b1;
        #1;
        pc_seen = pc_enable_out;
        @(posedge clk_in); #1;
        pc_seen = pc_seen | pc_enable_out;
        vectors++; if (state_out !== 3'd0 || data_mem_re_out !== 1'b0 || data_mem_we_out !== 1'b0 || instr_mem_re_out !== 1'b0)
            begin miscompares++; $display("FAIL mid_mem_reset got state %0d re %b we %b ire %b expected 0 0 0 0",
                state_out, data_mem_re_out, data_mem_we_out, instr_mem_re_out); end
        vectors++; if (pc_seen !== 1'b0) begin miscompares++; $display("FAIL mid_mem_no_retire got %b expected 0", pc_seen); end
        reset_in = 1'b0;
        #1;
        vectors++; if (state_out !== 3'd0 || instr_mem_re_out !== 1'b1)
            begin miscompares++; $display("FAIL mid_mem_release got state %0d ire %b expected 0 1", state_out, instr_mem_re_out); end
        run_instr(6'b000000, 6'b100101, 0, 1'b0);
        vectors++; if (cyc !== 4 || exec_func !== 6'b100101) begin miscompares++; $display("FAIL post_reset_or got cyc %0d func %b expected 4 100101", cyc, exec_func); end
    endtask

    task automatic test_back_to_back;
        int total;
        total = 0;
        run_instr(6'b101011, 6'b0, 0, 1'b0); total += cyc;
        run_instr(6'b100000, 6'b0, 2, 1'b0); total += cyc;
        run_instr(6'b001000, 6'b0, 0, 1'b0); total += cyc;
        vectors++; if (total !== 4 + 7 + 4) begin miscompares++; $display("FAIL back_to_back got %0d cycles expected 15", total); end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_addi;
        test_loads;
        test_stores;
        test_timeout;
        test_illegal;
        test_branch;
        test_reset_mid_mem;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
